mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester.
- Serialises requests with a small FSM and allows one outstanding transaction at a time.
- Routes the response back to the requester that issued it.
- Sits between the fetch/memory pipeline stages and the memory macro; also supplies the fetch stage's stall qualifier.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_prio.sv | 21 ++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the fetch/load-store memory arbiter.
package mem_arbiter_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] instr_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        RSP_I,
        RSP_D
    } arb_state_t;

    typedef struct packed {
        logic       we;
        logic [3:0] be;
        data_t      addr;
        data_t      wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_prio.sv
// arb_prio: picks the winner of a fresh arbitration; data first unless fetch has waited MAX_WAIT grants.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 2,
    parameter int CNT_W    = $clog2(MAX_WAIT + 2)
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] wait_cnt,
    output logic             sel_i,
    output logic             sel_d
);

    logic starved;

    assign starved = if_req && wait_cnt == CNT_W'(MAX_WAIT);
    assign sel_d   = d_req && !starved;
    assign sel_i   = if_req && !sel_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store accesses onto one single-ported memory,
// one outstanding transaction at a time, and routes each response back to its issuer.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              if_stall
);

    localparam int CNT_W = $clog2(MAX_WAIT + 2);

    arb_state_t       state, state_n;
    logic [CNT_W-1:0] wait_cnt;
    logic             drop_if, drop_n;
    logic             idle, sel_i, sel_d, cur_i, cur_d, rsp_i, rsp_d;
    mem_req_t         mreq;

    arb_prio #(
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) u_prio (
        .if_req  (if_req),
        .d_req   (d_req),
        .wait_cnt(wait_cnt),
        .sel_i   (sel_i),
        .sel_d   (sel_d)
    );

    // IDLE arbitrates and presents the winner in the same cycle; REQ_x keeps the earlier choice
    assign idle  = state == IDLE && rst_n;
    assign cur_i = (idle && sel_i) || state == REQ_I;
    assign cur_d = (idle && sel_d) || state == REQ_D;
    assign rsp_i = state == RSP_I && mem_rvalid;
    assign rsp_d = state == RSP_D && mem_rvalid;

    assign mreq = cur_d ? mem_req_t'{we: d_we, be: d_we ? d_be : BE_WORD, addr: 32'(d_addr), wdata: d_wdata}
                : cur_i ? mem_req_t'{we: 1'b0, be: BE_WORD, addr: 32'(if_addr), wdata: '0}
                : '0;

    assign mem_req   = cur_i || cur_d;
    assign mem_we    = mreq.we;
    assign mem_be    = mreq.be;
    assign mem_addr  = mreq.addr[ADDR_W-1:0];
    assign mem_wdata = mreq.wdata;

    assign if_gnt    = cur_i && mem_gnt;
    assign d_gnt     = cur_d && mem_gnt;
    assign if_rvalid = rsp_i && !drop_if && !if_flush;
    assign d_rvalid  = rsp_d;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign if_stall  = rst_n && if_req && !if_gnt;

    always_comb begin
        state_n = if_gnt ? RSP_I
                : d_gnt ? RSP_D
                : (cur_i && if_flush) ? IDLE
                : cur_i ? REQ_I
                : cur_d ? REQ_D
                : (rsp_i || rsp_d) ? IDLE
                : state;
        drop_n  = rsp_i ? 1'b0
                : (if_flush && (state == RSP_I || if_gnt)) ? 1'b1
                : drop_if;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            drop_if  <= 1'b0;
        end else begin
            state    <= state_n;
            drop_if  <= drop_n;
            wait_cnt <= (!if_req || if_gnt) ? '0
                      : (d_gnt && wait_cnt != CNT_W'(MAX_WAIT)) ? wait_cnt + 1'b1
                      : wait_cnt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAX_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_be = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, if_stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .if_stall(if_stall)
    );

    // Outstanding-transaction tracker for the memory-side protocol assertions
    logic out_tb;
    logic stray_ok = 1'b0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) out_tb <= 1'b0;
        else if (mem_rvalid) out_tb <= 1'b0;
        else if (mem_req && mem_gnt) out_tb <= 1'b1;

    assert property (@(posedge clk) disable iff (!rst_n) !(mem_req && mem_gnt && mem_rvalid))
        else $error("FAIL gnt_rvalid_overlap");
    assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid |-> (out_tb || stray_ok))
        else $error("FAIL stray_rvalid");

    typedef struct {
        logic ir, dr, dwe;
        logic [3:0] dbe;
        logic gnt;
        logic igt, dgt, mreq, mwe;
        logic [3:0] mbe;
        logic [31:0] maddr;
        logic stall;
    } vec_t;

    vec_t tbl [8];
    logic [1:0] fexp [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    int wc, lat;
    bit outst, who_d, pend, pwho_d, got_i, got_d, gi, gd;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0; d_be = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 4'h0, 32'h0,   0};
        tbl[1] = '{1, 0, 0, 4'h0, 1, 1, 0, 1, 0, 4'hF, 32'h40,  0};
        tbl[2] = '{1, 0, 0, 4'h0, 0, 0, 0, 1, 0, 4'hF, 32'h40,  1};
        tbl[3] = '{0, 1, 0, 4'h3, 1, 0, 1, 1, 0, 4'hF, 32'h100, 0};
        tbl[4] = '{0, 1, 1, 4'h3, 1, 0, 1, 1, 1, 4'h3, 32'h100, 0};
        tbl[5] = '{1, 1, 0, 4'h3, 1, 0, 1, 1, 0, 4'hF, 32'h100, 1};
        tbl[6] = '{1, 1, 1, 4'h3, 0, 0, 0, 1, 1, 4'h3, 32'h100, 1};
        tbl[7] = '{0, 1, 1, 4'h5, 0, 0, 0, 1, 1, 4'h5, 32'h100, 0};

        // Single-cycle arbitration from IDLE after reset
        for (int i = 0; i < 8; i++) begin
            do_reset;
            chk($sformatf("rst%0d", i), {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, mem_be, if_stall}, 0);
            if_req = tbl[i].ir; if_addr = 32'h40;
            d_req = tbl[i].dr; d_we = tbl[i].dwe; d_be = tbl[i].dbe; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
            mem_gnt = tbl[i].gnt;
            mid;
            chk($sformatf("vec%0d", i), {if_gnt, d_gnt, mem_req, mem_we, mem_be, mem_addr, if_stall},
                {tbl[i].igt, tbl[i].dgt, tbl[i].mreq, tbl[i].mwe, tbl[i].mbe, tbl[i].maddr, tbl[i].stall});
        end

        // Fetch only, zero-wait grant, response two cycles later
        do_reset;
        if_req = 1; if_addr = 32'h40; mem_gnt = 1;
        mid; chk("a_gnt", {if_gnt, mem_req, mem_addr}, {2'b11, 32'h40}); tick;
        if_req = 0;
        mid; chk("a_wait", {if_rvalid, mem_req}, 0); tick;
        mem_rvalid = 1; mem_rdata = 32'h13;
        mid; chk("a_rsp", {if_rvalid, if_rdata, d_rvalid}, {1'b1, 32'h13, 1'b0}); tick;
        mem_rvalid = 0; if_req = 1;
        mid; chk("a_idle", if_gnt, 1); tick;

        // Simultaneous requests: data first, fetch after the response bubble
        do_reset;
        if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h100; mem_gnt = 1;
        mid; chk("b_d", {d_gnt, if_gnt, mem_addr, mem_be, mem_we}, {2'b10, 32'h100, 4'hF, 1'b0}); tick;
        d_req = 0;
        mid; chk("b_hold", {if_gnt, mem_req, if_stall}, 3'b001); tick;
        mem_rvalid = 1; mem_rdata = 32'h55;
        mid; chk("b_rsp", {d_rvalid, d_rdata, if_rvalid, if_gnt, mem_req}, {1'b1, 32'h55, 3'b000}); tick;
        mem_rvalid = 0;
        mid; chk("b_i", {if_gnt, mem_addr, mem_be}, {1'b1, 32'h40, 4'hF}); tick;

        // Fairness: data held continuously, fetch pending
        do_reset;
        if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h200; mem_gnt = 1;
        for (int k = 0; k < 6; k++) begin
            mid;
            chk($sformatf("c_gnt%0d", k), {if_gnt, d_gnt}, fexp[k]);
            chk($sformatf("c_stall%0d", k), if_stall, fexp[k] != 2'b10);
            tick;
            mem_rvalid = 1;
            mid; chk($sformatf("c_pend%0d", k), {mem_req, if_stall}, 2'b01); tick;
            mem_rvalid = 0;
        end

        // Store with memory grant delayed three cycles
        do_reset;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            mem_gnt = (c == 3);
            mid;
            chk($sformatf("d_c%0d", c), {mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_gnt},
                {2'b11, 4'b0011, 32'h100, 32'hDEADBEEF, 1'(c == 3)});
            tick;
        end
        d_req = 0; mem_gnt = 0;
        mid; chk("d_wait", {d_rvalid, mem_req}, 0); tick;
        mem_rvalid = 1; mem_rdata = 0;
        mid; chk("d_ack", d_rvalid, 1); tick;
        mem_rvalid = 0;

        // Flush while the fetch response is outstanding
        do_reset;
        if_req = 1; if_addr = 32'h80; mem_gnt = 1;
        mid; chk("e_gnt", if_gnt, 1); tick;
        if_req = 0; if_flush = 1;
        mid; tick;
        if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h11;
        mid; chk("e_drop", if_rvalid, 0); tick;
        mem_rvalid = 0;
        mid; tick;
        if_req = 1; if_addr = 32'h84;
        mid; chk("e_gnt2", if_gnt, 1); tick;
        if_req = 0;
        mid; tick;
        mem_rvalid = 1; mem_rdata = 32'h22;
        mid; chk("e_rsp", {if_rvalid, if_rdata}, {1'b1, 32'h22}); tick;
        mem_rvalid = 0;

        // Flush before grant withdraws the fetch request
        do_reset;
        if_req = 1; if_addr = 32'h90; mem_gnt = 0;
        mid; chk("g_req", {mem_req, if_gnt}, 2'b10); tick;
        if_flush = 1;
        mid; chk("g_flush", {mem_req, if_gnt}, 2'b10); tick;
        if_flush = 0; if_req = 0;
        mid; chk("g_drop", mem_req, 0); tick;
        d_req = 1; d_addr = 32'h300; mem_gnt = 1;
        mid; chk("g_idle", {d_gnt, mem_addr}, {1'b1, 32'h300}); tick;

        // Reset in RSP_D aborts the load; a stale response afterwards is ignored
        do_reset;
        d_req = 1; d_addr = 32'h100; mem_gnt = 1;
        mid; chk("f_gnt", d_gnt, 1); tick;
        d_req = 0; mem_gnt = 0;
        mid;
        rst_n = 0; if_req = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
        #1;
        chk("f_rst", {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we, mem_be, mem_addr, if_stall}, 0);
        @(posedge clk); #1;
        rst_n = 1; if_req = 0; stray_ok = 1;
        mid; chk("f_stale", {d_rvalid, if_rvalid}, 0); tick;
        stray_ok = 0; mem_rvalid = 0; if_req = 1; if_addr = 32'h40; mem_gnt = 1;
        mid; chk("f_idle", if_gnt, 1); tick;

        // Randomized traffic against a transaction-level model
        do_reset;
        wc = 0; outst = 0; pend = 0; got_i = 0; got_d = 0; lat = 0;
        for (int c = 0; c < 800; c++) begin
            if (!if_req || got_i) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = 32'h1000 | ($urandom & 32'hFC);
            end
            if (!d_req || got_d) begin
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom);
                d_be = 4'($urandom);
                d_addr = 32'h8000 | ($urandom & 32'hFF);
                d_wdata = $urandom;
            end
            got_i = 0; got_d = 0;
            mem_rvalid = outst && lat == 0;
            mem_rdata = $urandom;
            mem_gnt = !mem_rvalid && $urandom_range(0, 2) != 0;
            mid;
            chk("r_rv", {if_rvalid, d_rvalid}, {mem_rvalid && !who_d, mem_rvalid && who_d});
            if (mem_rvalid) chk("r_rdata", who_d ? d_rdata : if_rdata, mem_rdata);
            if (!pend && !outst && (if_req || d_req)) begin
                pend = 1;
                pwho_d = d_req && !(if_req && wc == MAX_WAIT);
            end
            chk("r_mreq", mem_req, pend);
            if (pend)
                chk("r_fld", {mem_we, mem_be, mem_addr},
                    pwho_d ? {d_we, d_we ? d_be : 4'hF, d_addr} : {1'b0, 4'hF, if_addr});
            if (pend && pwho_d && d_we) chk("r_wdata", mem_wdata, d_wdata);
            gi = pend && mem_gnt && !pwho_d;
            gd = pend && mem_gnt && pwho_d;
            chk("r_gnt", {if_gnt, d_gnt}, {gi, gd});
            chk("r_stall", if_stall, if_req && !gi);
            if (mem_rvalid) outst = 0;
            else if (outst) lat--;
            wc = (!if_req || gi) ? 0 : (gd && wc < MAX_WAIT) ? wc + 1 : wc;
            if (gi || gd) begin
                outst = 1; who_d = gd; lat = $urandom_range(0, 2); pend = 0;
                got_i = gi; got_d = gd;
            end
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
